// File: rtl/sequence_round_checker_if.sv
// rtl/sequence_round_checker_if.sv - game-side handshake bundle for the sequence round checker
interface sequence_round_checker_if #(
    parameter int LEN_W = 6
);
    logic             start;
    logic [1:0]       rand_num;
    logic             key_valid;
    logic [1:0]       key_num;
    logic             show_valid;
    logic [1:0]       show_num;
    logic             awaiting_input;
    logic             round_ok;
    logic             game_over;
    logic             win;
    logic [LEN_W-1:0] level;

    // Game top / display side: issues start, random values and keys, consumes status
    modport master (
        output start, rand_num, key_valid, key_num,
        input  show_valid, show_num, awaiting_input, round_ok, game_over, win, level
    );

    // Checker side
    modport slave (
        input  start, rand_num, key_valid, key_num,
        output show_valid, show_num, awaiting_input, round_ok, game_over, win, level
    );
endinterface

// File: rtl/sequence_round_checker.sv
// rtl/sequence_round_checker.sv - builds, plays back and checks a growing random key sequence
module sequence_round_checker #(
    parameter int MAX_LEN     = 32,
    parameter int LEN_W       = 6,
    parameter int SHOW_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 12500000
) (
    input  logic                    clock,
    input  logic                    reset,
    sequence_round_checker_if.slave bus
);
    localparam int MAX_CYC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int ADDR_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [TIMER_W-1:0] SHOW_LAST = TIMER_W'(SHOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [LEN_W-1:0]   LEN_MAX   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);

    typedef enum logic [2:0] {
        IDLE, APPEND, SHOW_ON, SHOW_OFF, INPUT, LOSE, WIN
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [LEN_W-1:0]   length;
    logic [LEN_W-1:0]   idx;
    logic [TIMER_W-1:0] timer;
    logic               round_ok_q;

    // Sequence storage is never reset; only entries below length are ever read
    logic [1:0] mem [0:(1<<ADDR_W)-1];

    logic [1:0] cur_num;
    logic       idx_last;
    logic       key_hit;
    logic       show_done;
    logic       gap_done;

    assign cur_num   = mem[idx[ADDR_W-1:0]];
    assign idx_last  = (idx == length - LEN_ONE);
    assign key_hit   = bus.key_valid && (bus.key_num == cur_num);
    assign show_done = (timer == SHOW_LAST);
    assign gap_done  = (timer == GAP_LAST);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision; keys only matter in INPUT, start only in IDLE/LOSE/WIN
    always_comb begin
        state_next = state;
        case (state)
            IDLE, LOSE, WIN: if (bus.start) state_next = APPEND;
            APPEND:          state_next = SHOW_ON;
            SHOW_ON:         if (show_done) state_next = SHOW_OFF;
            SHOW_OFF: begin
                if (gap_done) state_next = idx_last ? INPUT : SHOW_ON;
            end
            INPUT: begin
                if (bus.key_valid) begin
                    if (!key_hit)      state_next = LOSE;
                    else if (idx_last) state_next = (length == LEN_MAX) ? WIN : APPEND;
                end
            end
            default:         state_next = IDLE;
        endcase
    end

    // Length, step index, phase timer and the round-complete pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            length     <= '0;
            idx        <= '0;
            timer      <= '0;
            round_ok_q <= 1'b0;
        end else begin
            round_ok_q <= 1'b0;
            case (state)
                IDLE, LOSE, WIN: begin
                    if (bus.start) begin
                        length <= '0;
                        idx    <= '0;
                        timer  <= '0;
                    end
                end
                APPEND: begin
                    length <= length + LEN_ONE;
                    idx    <= '0;
                    timer  <= '0;
                end
                SHOW_ON: begin
                    timer <= show_done ? '0 : timer + 1'b1;
                end
                SHOW_OFF: begin
                    if (gap_done) begin
                        timer <= '0;
                        idx   <= idx_last ? '0 : idx + LEN_ONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                INPUT: begin
                    if (key_hit) begin
                        if (idx_last) begin
                            idx        <= '0;
                            round_ok_q <= 1'b1;
                        end else begin
                            idx <= idx + LEN_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Capture the sampled random value into the next free slot
    always_ff @(posedge clock) begin
        if (state == APPEND) begin
            mem[length[ADDR_W-1:0]] <= bus.rand_num;
        end
    end

    assign bus.level    = length;
    assign bus.round_ok = round_ok_q;

    // Status outputs decoded from the state register only
    always_comb begin
        bus.show_valid     = 1'b0;
        bus.show_num       = 2'd0;
        bus.awaiting_input = 1'b0;
        bus.game_over      = 1'b0;
        bus.win            = 1'b0;
        case (state)
            SHOW_ON: begin
                bus.show_valid = 1'b1;
                bus.show_num   = cur_num;
            end
            INPUT:   bus.awaiting_input = 1'b1;
            LOSE:    bus.game_over      = 1'b1;
            WIN:     bus.win            = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sequence_round_checker.sv
// tb/tb_sequence_round_checker.sv - randomized scoreboard bench for sequence_round_checker
module tb_sequence_round_checker;
    localparam int MAX_LEN     = 4;
    localparam int LEN_W       = 3;
    localparam int SHOW_CYCLES = 2;
    localparam int GAP_CYCLES  = 1;

    localparam int K_SHOW = 0;
    localparam int K_ROK  = 1;
    localparam int K_LOSE = 2;
    localparam int K_WIN  = 3;

    typedef struct {
        int kind;
        int val;
        int lvl;
        int on_len;
        int gap_len;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    sequence_round_checker_if #(.LEN_W(LEN_W)) bus();

    sequence_round_checker #(
        .MAX_LEN(MAX_LEN), .LEN_W(LEN_W),
        .SHOW_CYCLES(SHOW_CYCLES), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    ev_t exp_q[$];
    int  seq[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  ev_no    = 0;
    int  res;

    function automatic ev_t mk(input int k, input int v, input int l, input int on, input int gap);
        ev_t e;
        e.kind = k; e.val = v; e.lvl = l; e.on_len = on; e.gap_len = gap;
        return e;
    endfunction

    task automatic report;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    task automatic chk(input string name, input int got, input int expv);
        n_checks++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, expv);
    endtask

    task automatic cmp_event(input ev_t got);
        ev_t e;
        n_checks++;
        ev_no++;
        if (exp_q.size() == 0) begin
            $display("FAIL event%0d unexpected: kind=%0d val=%0d lvl=%0d on=%0d gap=%0d",
                     ev_no, got.kind, got.val, got.lvl, got.on_len, got.gap_len);
            return;
        end
        e = exp_q.pop_front();
        if (got.kind == e.kind && got.val == e.val && got.lvl == e.lvl &&
            got.on_len == e.on_len && got.gap_len == e.gap_len) begin
            n_pass++;
        end else begin
            $display("FAIL event%0d: got kind=%0d val=%0d lvl=%0d on=%0d gap=%0d expected kind=%0d val=%0d lvl=%0d on=%0d gap=%0d",
                     ev_no, got.kind, got.val, got.lvl, got.on_len, got.gap_len,
                     e.kind, e.val, e.lvl, e.on_len, e.gap_len);
        end
    endtask

    // Reference model: every element of the sequence is shown once per round
    task automatic push_shows;
        foreach (seq[j]) exp_q.push_back(mk(K_SHOW, seq[j], seq.size(), SHOW_CYCLES, GAP_CYCLES));
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Monitor: turns DUT activity into events and checks them against the queue
    bit m_run, m_pend, m_rok, m_over, m_win, m_bad;
    int m_len, m_val, m_lvl, m_dark;

    always @(negedge clock) begin
        if (!reset) begin
            m_run = 0; m_pend = 0; m_rok = 0; m_over = 0; m_win = 0; m_bad = 0;
        end else begin
            if (bus.show_valid) begin
                if (m_pend) begin
                    cmp_event(mk(K_SHOW, m_bad ? -1 : m_val, m_lvl, m_len, m_dark));
                    m_pend = 0;
                end
                if (!m_run) begin
                    m_run = 1; m_len = 1; m_bad = 0;
                    m_val = int'(bus.show_num);
                    m_lvl = int'(bus.level);
                end else begin
                    m_len++;
                    if (int'(bus.show_num) != m_val) m_bad = 1;
                end
            end else begin
                if (bus.show_num != 2'd0) m_bad = 1;
                if (m_run) begin
                    m_run = 0; m_pend = 1; m_dark = 1;
                end else if (m_pend) begin
                    if (bus.awaiting_input) begin
                        cmp_event(mk(K_SHOW, m_bad ? -1 : m_val, m_lvl, m_len, m_dark));
                        m_pend = 0;
                    end else begin
                        m_dark++;
                    end
                end
            end
            if (m_rok) chk("round_ok_width", int'(bus.round_ok), 0);
            if (bus.round_ok && !m_rok)   cmp_event(mk(K_ROK, 0, int'(bus.level), 0, 0));
            if (bus.game_over && !m_over) cmp_event(mk(K_LOSE, 0, int'(bus.level), 0, 0));
            if (bus.win && !m_win)        cmp_event(mk(K_WIN, 0, int'(bus.level), 0, 0));
            m_rok  = bus.round_ok;
            m_over = bus.game_over;
            m_win  = bus.win;
        end
    end

    task automatic new_game(input int r);
        bus.start    = 1'b1;
        bus.rand_num = 2'(r);
        seq.delete();
        seq.push_back(r);
        push_shows();
        tick;
        bus.start = 1'b0;
        tick;
        bus.rand_num = 2'($urandom_range(0, 3));
    endtask

    // Waits out playback while throwing stray keys and starts at the DUT
    task automatic wait_input;
        for (int c = 0; c < 200; c++) begin
            if (bus.awaiting_input) return;
            if ($urandom_range(0, 2) == 0) begin
                bus.key_valid = 1'b1;
                bus.key_num   = 2'(seq[$urandom_range(0, seq.size() - 1)]);
                bus.start     = ($urandom_range(0, 3) == 0);
            end
            tick;
            bus.key_valid = 1'b0;
            bus.start     = 1'b0;
            bus.rand_num  = 2'($urandom_range(0, 3));
        end
        n_checks++;
        $display("FAIL wait_input: awaiting_input still 0 after 200 cycles");
        report();
    endtask

    // res: 0 = next round follows, 1 = lost, 2 = won
    task automatic play_round(input int wrong_pos, input int wrong_key, input int next_r, output int r_out);
        int len, k, nr;
        len   = seq.size();
        r_out = 0;
        wait_input();
        for (int i = 0; i < len; i++) begin
            if (i == wrong_pos) k = (wrong_key >= 0) ? wrong_key : int'((seq[i] + $urandom_range(1, 3)) % 4);
            else k = seq[i];
            bus.key_valid = 1'b1;
            bus.key_num   = 2'(k);
            bus.start     = ($urandom_range(0, 4) == 0);
            if (i == wrong_pos) begin
                exp_q.push_back(mk(K_LOSE, 0, len, 0, 0));
                tick;
                bus.key_valid = 1'b0;
                bus.start     = 1'b0;
                r_out = 1;
                return;
            end
            if (i == len - 1) begin
                nr = (next_r >= 0) ? next_r : int'($urandom_range(0, 3));
                bus.rand_num = 2'(nr);
                exp_q.push_back(mk(K_ROK, 0, len, 0, 0));
                if (len == MAX_LEN) begin
                    exp_q.push_back(mk(K_WIN, 0, len, 0, 0));
                    r_out = 2;
                end else begin
                    seq.push_back(nr);
                    push_shows();
                end
                tick;
                bus.key_valid = 1'b0;
                bus.start     = 1'b0;
                tick;
                bus.rand_num = 2'($urandom_range(0, 3));
            end else begin
                tick;
                bus.key_valid = 1'b0;
                bus.start     = 1'b0;
                repeat ($urandom_range(0, 2)) tick;
            end
        end
    endtask

    task automatic stray_keys(input int n);
        for (int i = 0; i < n; i++) begin
            bus.key_valid = 1'b1;
            bus.key_num   = 2'($urandom_range(0, 3));
            tick;
            bus.key_valid = 1'b0;
            tick;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_show_valid"}, int'(bus.show_valid), 0);
        chk({tag, "_show_num"}, int'(bus.show_num), 0);
        chk({tag, "_awaiting"}, int'(bus.awaiting_input), 0);
        chk({tag, "_round_ok"}, int'(bus.round_ok), 0);
        chk({tag, "_game_over"}, int'(bus.game_over), 0);
        chk({tag, "_win"}, int'(bus.win), 0);
        chk({tag, "_level"}, int'(bus.level), 0);
    endtask

    initial begin
        #400000;
        n_checks++;
        $display("FAIL watchdog: simulation time limit reached");
        report();
    end

    initial begin
        bus.start = 1'b0; bus.rand_num = 2'd0; bus.key_valid = 1'b0; bus.key_num = 2'd0;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk_all_zero("in_reset");
        reset = 1'b1;
        tick;
        chk_all_zero("after_reset");
        bus.key_valid = 1'b1; bus.key_num = 2'd2;
        tick;
        bus.key_valid = 1'b0;
        repeat (3) tick;
        chk_all_zero("idle_key");

        // Directed: {2} correct, then {2,1} with a wrong second key
        new_game(2);
        chk("first_level", int'(bus.level), 1);
        play_round(-1, -1, 1, res);
        play_round(1, 0, -1, res);
        chk("lose_res", res, 1);
        chk("lose_game_over", int'(bus.game_over), 1);
        chk("lose_awaiting", int'(bus.awaiting_input), 0);
        chk("lose_level", int'(bus.level), 2);
        stray_keys(3);
        chk("lose_hold_game_over", int'(bus.game_over), 1);
        chk("lose_hold_level", int'(bus.level), 2);

        // Win path from LOSE
        new_game($urandom_range(0, 3));
        chk("restart_level", int'(bus.level), 1);
        chk("restart_game_over", int'(bus.game_over), 0);
        for (int r = 0; r < MAX_LEN; r++) begin
            play_round(-1, -1, -1, res);
            if (res != 0) break;
        end
        chk("win_flag", int'(bus.win), 1);
        chk("win_level", int'(bus.level), MAX_LEN);
        stray_keys(3);
        chk("win_hold_flag", int'(bus.win), 1);
        chk("win_hold_level", int'(bus.level), MAX_LEN);

        // Random games
        for (int g = 0; g < 8; g++) begin
            int wp;
            new_game($urandom_range(0, 3));
            chk("game_start_level", int'(bus.level), 1);
            for (int r = 0; r < MAX_LEN; r++) begin
                wp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, seq.size() - 1)) : -1;
                play_round(wp, -1, -1, res);
                if (res != 0) break;
            end
            if (res == 1) begin
                chk("rnd_lose_flag", int'(bus.game_over), 1);
                chk("rnd_lose_level", int'(bus.level), seq.size());
            end else begin
                chk("rnd_win_flag", int'(bus.win), 1);
                chk("rnd_win_level", int'(bus.level), MAX_LEN);
            end
        end

        // Asynchronous reset in the middle of SHOW_ON
        new_game($urandom_range(0, 3));
        chk("pre_reset_show", int'(bus.show_valid), 1);
        #3;
        reset = 1'b0;
        #1;
        chk("async_show_valid", int'(bus.show_valid), 0);
        chk("async_level", int'(bus.level), 0);
        exp_q.delete();
        seq.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;
        seq.push_back(0);
        stray_keys(2);
        repeat (4) tick;
        chk_all_zero("post_reset_idle");

        new_game($urandom_range(0, 3));
        for (int r = 0; r < MAX_LEN; r++) begin
            play_round(-1, -1, -1, res);
            if (res != 0) break;
        end
        chk("final_win", int'(bus.win), 1);

        repeat (5) tick;
        chk("queue_empty", exp_q.size(), 0);
        report();
    end
endmodule
